// File: rtl/adiv5_memap_seq_if.sv
// Client request/response channel plus ADIv5 command/response FIFO signals
// of the MEM-AP access sequencer.
interface adiv5_memap_seq_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 40;
  localparam int unsigned RESP_W = 35;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_wren;
  logic              cmd_full;
  logic [RESP_W-1:0] resp_data;
  logic              resp_rden;
  logic              resp_empty;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           cmd_full, resp_data, resp_empty,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           cmd_data, cmd_wren, resp_rden
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           cmd_full, resp_data, resp_empty,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           cmd_data, cmd_wren, resp_rden
  );
endinterface

// File: rtl/adiv5_memap_seq.sv
// Turns single 32-bit client accesses into ADIv5 DP/AP command sequences,
// caching the SELECT/CSW setup and the last TAR value between requests.
module adiv5_memap_seq #(
  parameter logic [7:0]  AP_SEL  = 8'h00,
  parameter logic [31:0] CSW_VAL = 32'h23000002
) (
  input logic              clk,
  input logic              rst,
  adiv5_memap_seq_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAR_W  = 30;
  localparam int unsigned CMD_W  = 40;
  localparam logic [2:0]  STAT_OK = 3'b100;

  typedef enum logic [2:0] {IDLE, SEL, CSW, TAR, DRW, RDBUF, WAIT, DONE} state_t;

  state_t            state, state_d, ret, ret_d;
  logic [1:0]        phase, phase_d;
  logic              init_done, init_done_d, tar_valid, tar_valid_d;
  logic [TAR_W-1:0]  tar_q, tar_q_d;
  logic              lat_write, lat_write_d;
  logic [DATA_W-1:0] lat_addr, lat_addr_d, lat_wdata, lat_wdata_d;
  logic              req_ready, req_ready_d, rsp_valid, rsp_valid_d;
  logic              rsp_err, rsp_err_d, cmd_wren, cmd_wren_d, resp_rden, resp_rden_d;
  logic [DATA_W-1:0] rsp_rdata, rsp_rdata_d;
  logic [CMD_W-1:0]  cmd_data, cmd_data_d, issue_cmd;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.cmd_data  = cmd_data;
  assign bus.cmd_wren  = cmd_wren;
  assign bus.resp_rden = resp_rden;

  // First step of a sequence given the cached debug-port setup.
  function automatic state_t route(input logic init, input logic tv,
                                   input logic [TAR_W-1:0] tq, input logic [DATA_W-1:0] addr);
    if (!init) return SEL;
    if (!tv || ({tq, 2'b00} != addr)) return TAR;
    return DRW;
  endfunction

  // Command word {DATA, ADDR[5:0], APnDP, RnW} for the current issue state.
  always_comb begin
    issue_cmd = '0;
    case (state)
      SEL:     issue_cmd = {AP_SEL, 24'h0, 6'd2, 1'b0, 1'b0};
      CSW:     issue_cmd = {CSW_VAL, 6'd0, 1'b1, 1'b0};
      TAR:     issue_cmd = {lat_addr, 6'd1, 1'b1, 1'b0};
      DRW:     issue_cmd = {(lat_write ? lat_wdata : 32'h0), 6'd3, 1'b1, ~lat_write};
      RDBUF:   issue_cmd = {32'h0, 6'd3, 1'b0, 1'b1};
      default: issue_cmd = '0;
    endcase
  end

  always_comb begin
    state_d     = state;
    ret_d       = ret;
    phase_d     = phase;
    init_done_d = init_done;
    tar_valid_d = tar_valid;
    tar_q_d     = tar_q;
    lat_write_d = lat_write;
    lat_addr_d  = lat_addr;
    lat_wdata_d = lat_wdata;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    cmd_data_d  = cmd_data;
    cmd_wren_d  = 1'b0;
    resp_rden_d = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid && req_ready) begin
          lat_write_d = bus.req_write;
          lat_addr_d  = bus.req_addr & ~32'h3;
          lat_wdata_d = bus.req_wdata;
          state_d     = route(init_done, tar_valid, tar_q, bus.req_addr & ~32'h3);
        end
      end
      SEL, CSW, TAR, DRW, RDBUF: begin
        if (!bus.cmd_full) begin
          cmd_wren_d = 1'b1;
          cmd_data_d = issue_cmd;
          ret_d      = state;
          phase_d    = 2'd0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // phase 0: wait for a response, 1: read strobe out, 2: response data valid
        case (phase)
          2'd0: begin
            if (!bus.resp_empty) begin
              resp_rden_d = 1'b1;
              phase_d     = 2'd1;
            end
          end
          2'd1: phase_d = 2'd2;
          default: begin
            phase_d = 2'd0;
            if (bus.resp_data[2:0] != STAT_OK) begin
              state_d     = DONE;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
              init_done_d = 1'b0;
              tar_valid_d = 1'b0;
            end else begin
              case (ret)
                SEL: state_d = CSW;
                CSW: begin
                  init_done_d = 1'b1;
                  state_d     = route(1'b1, tar_valid, tar_q, lat_addr);
                end
                TAR: begin
                  tar_q_d     = lat_addr[31:2];
                  tar_valid_d = 1'b1;
                  state_d     = DRW;
                end
                DRW: begin
                  if (lat_write) begin
                    state_d     = DONE;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                  end else begin
                    state_d = RDBUF;
                  end
                end
                default: begin
                  state_d     = DONE;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = bus.resp_data[34:3];
                end
              endcase
            end
          end
        endcase
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ret       <= IDLE;
      phase     <= 2'd0;
      init_done <= 1'b0;
      tar_valid <= 1'b0;
      tar_q     <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cmd_data  <= '0;
      cmd_wren  <= 1'b0;
      resp_rden <= 1'b0;
    end else begin
      state     <= state_d;
      ret       <= ret_d;
      phase     <= phase_d;
      init_done <= init_done_d;
      tar_valid <= tar_valid_d;
      tar_q     <= tar_q_d;
      lat_write <= lat_write_d;
      lat_addr  <= lat_addr_d;
      lat_wdata <= lat_wdata_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      cmd_data  <= cmd_data_d;
      cmd_wren  <= cmd_wren_d;
      resp_rden <= resp_rden_d;
    end
  end
endmodule

// File: tb/tb_adiv5_memap_seq.sv
// Randomized bench for adiv5_memap_seq: a FIFO agent answers each command and
// a transaction-level model predicts command lists and completions.
module tb_adiv5_memap_seq;
  localparam logic [2:0]  OK     = 3'b100;
  localparam logic [7:0]  APSEL  = 8'h00;
  localparam logic [31:0] CSWV   = 32'h23000002;
  localparam int K_NONE = 0, K_SEL = 1, K_CSW = 2, K_TAR = 3, K_DRW = 4, K_RDBUF = 5;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  adiv5_memap_seq_if bus();
  adiv5_memap_seq #(.AP_SEL(APSEL), .CSW_VAL(CSWV)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [39:0] cmd_log[$];
  logic [34:0] resp_q[$];
  logic [34:0] fl_resp[$];
  int          fl_delay[$];
  int          fail_kind;
  logic [2:0]  fail_stat;
  logic [31:0] drw_val, rdbuf_val;
  logic        m_init, m_tv;
  logic [29:0] m_tar;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int kind_of(input logic [39:0] c);
    if (!c[1] && c[7:2] == 6'd2) return K_SEL;
    if ( c[1] && c[7:2] == 6'd0) return K_CSW;
    if ( c[1] && c[7:2] == 6'd1) return K_TAR;
    if ( c[1] && c[7:2] == 6'd3) return K_DRW;
    if (!c[1] && c[7:2] == 6'd3) return K_RDBUF;
    return K_NONE;
  endfunction

  // FIFO agent: logs commands, answers each after 1-3 cycles, pops on RESP_RDEN.
  initial begin
    logic       rden_prev;
    int         k;
    logic [2:0] st;
    logic [31:0] d;
    bus.resp_empty = 1'b1;
    bus.resp_data  = '0;
    rden_prev      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        resp_q.delete();
        fl_resp.delete();
        fl_delay.delete();
        rden_prev = 1'b0;
      end else begin
        if (rden_prev) begin
          if (resp_q.size() == 0) check("rden_on_empty", 64'd1, 64'd0);
          else bus.resp_data = resp_q.pop_front();
        end
        rden_prev = bus.resp_rden;
        for (int i = 0; i < fl_delay.size(); i++) fl_delay[i] = fl_delay[i] - 1;
        while (fl_delay.size() > 0 && fl_delay[0] <= 0) begin
          resp_q.push_back(fl_resp.pop_front());
          void'(fl_delay.pop_front());
        end
        if (bus.cmd_wren) begin
          cmd_log.push_back(bus.cmd_data);
          k  = kind_of(bus.cmd_data);
          st = (k == fail_kind) ? fail_stat : OK;
          d  = (k == K_RDBUF) ? rdbuf_val : ((k == K_DRW) ? drw_val : $urandom);
          fl_resp.push_back({d, st});
          fl_delay.push_back(int'($urandom_range(1, 3)));
        end
      end
      bus.resp_empty = (resp_q.size() == 0);
    end
  end

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int fk, input logic [2:0] fs, input int full_hold,
                        input int ready_delay, input logic [31:0] dv, input logic [31:0] rv,
                        input string tag);
    int          kinds[$];
    logic [39:0] cmds[$];
    logic [31:0] am;
    logic        exp_err, acc, rdy;
    logic [31:0] exp_rdata;
    int          cyc;
    am = addr & ~32'h3;
    if (!m_init) begin
      kinds.push_back(K_SEL); cmds.push_back({APSEL, 24'h0, 6'd2, 1'b0, 1'b0});
      kinds.push_back(K_CSW); cmds.push_back({CSWV, 6'd0, 1'b1, 1'b0});
    end
    if (!m_init || !m_tv || m_tar != addr[31:2]) begin
      kinds.push_back(K_TAR); cmds.push_back({am, 6'd1, 1'b1, 1'b0});
    end
    kinds.push_back(K_DRW); cmds.push_back({(wr ? wdata : 32'h0), 6'd3, 1'b1, ~wr});
    if (!wr) begin
      kinds.push_back(K_RDBUF); cmds.push_back({32'h0, 6'd3, 1'b0, 1'b1});
    end
    exp_err   = 1'b0;
    exp_rdata = wr ? 32'h0 : rv;
    for (int i = 0; i < kinds.size(); i++) begin
      if (kinds[i] == fk) begin
        exp_err   = 1'b1;
        exp_rdata = 32'h0;
        while (cmds.size() > i + 1) void'(cmds.pop_back());
        break;
      end
    end

    fail_kind = fk; fail_stat = fs; drw_val = dv; rdbuf_val = rv;
    cmd_log.delete();
    if (full_hold > 0) bus.cmd_full = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    check({tag, "_accept"}, 64'(acc), 64'd1);
    bus.req_valid = 1'b0; bus.req_wdata = $urandom; bus.req_addr = $urandom;
    bus.req_write = 1'($urandom);
    if (full_hold > 0) begin
      for (int c = 0; c < full_hold; c++) begin
        check({tag, "_wren_while_full"}, 64'(bus.cmd_wren), 64'd0);
        @(posedge clk);
        #1;
      end
      bus.cmd_full = 1'b0;
    end
    cyc = 0;
    while (!bus.rsp_valid && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
    check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
    check({tag, "_ncmd"}, 64'(cmd_log.size()), 64'(cmds.size()));
    for (int i = 0; i < cmds.size() && i < cmd_log.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), 64'(cmd_log[i]), 64'(cmds[i]));
    for (int c = 0; c < ready_delay; c++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      check({tag, "_hold_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
      check({tag, "_hold_err"}, 64'(bus.rsp_err), 64'(exp_err));
      check({tag, "_hold_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.req_ready), 64'd1);

    if (exp_err) begin
      m_init = 1'b0; m_tv = 1'b0;
    end else begin
      m_init = 1'b1; m_tv = 1'b1; m_tar = addr[31:2];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({tag, "_cmd_wren"}, 64'(bus.cmd_wren), 64'd0);
    check({tag, "_resp_rden"}, 64'(bus.resp_rden), 64'd0);
    check({tag, "_cmd_data"}, 64'(bus.cmd_data), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] pool[4];
    logic [2:0]  stats[5];
    logic        acc, rdy;
    int          cyc, fk;
    pool[0] = 32'h20000004; pool[1] = 32'h20000100; pool[2] = 32'h30000000; pool[3] = 32'h4000ABC8;
    stats[0] = 3'b000; stats[1] = 3'b001; stats[2] = 3'b010; stats[3] = 3'b111; stats[4] = 3'b011;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.cmd_full = 1'b0;
    fail_kind = K_NONE; fail_stat = OK; drw_val = '0; rdbuf_val = '0;
    m_init = 1'b0; m_tv = 1'b0; m_tar = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #3 rst = 1'b0;
    #1 check("por_rel_ready_low", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("por_first_edge_ready", 64'(bus.req_ready), 64'd1);

    do_txn(1'b1, 32'h20000004, 32'hDEADBEEF, K_NONE, OK, 0, 0, $urandom, $urandom, "wr_first");
    do_txn(1'b0, 32'h20000004, $urandom, K_NONE, OK, 0, 0, 32'h11111111, 32'hCAFEF00D, "rd_cached");
    do_txn(1'b1, 32'h20000100, 32'h5555AAAA, K_TAR, 3'b001, 0, 0, $urandom, $urandom, "tar_err");
    do_txn(1'b0, 32'h20000100, $urandom, K_NONE, OK, 0, 0, $urandom, 32'h01234567, "rd_reinit");
    do_txn(1'b1, 32'h20000100, 32'h0BADF00D, K_NONE, OK, 10, 0, $urandom, $urandom, "full_hold");
    do_txn(1'b0, 32'h20000100, $urandom, K_NONE, OK, 0, 5, $urandom, 32'h89ABCDEF, "rsp_stall");

    // Reset while waiting for the TAR response of a new address.
    fail_kind = K_NONE;
    cmd_log.delete();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h30000000;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!bus.cmd_wren && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("mid_rst_saw_wren", 64'(bus.cmd_wren), 64'd1);
    #3 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    m_init = 1'b0; m_tv = 1'b0;
    #1 check("mid_rst_rel_ready_low", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_first_edge_ready", 64'(bus.req_ready), 64'd1);
    do_txn(1'b1, 32'h30000000, 32'h600DCAFE, K_NONE, OK, 0, 0, $urandom, $urandom, "after_rst");

    for (int t = 0; t < 40; t++) begin
      fk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : K_NONE;
      do_txn(1'($urandom), pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom,
             fk, stats[$urandom_range(0, 4)], int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom, $urandom, $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/adiv5_memap_seq.md
ADIV5_MEMAP_SEQ -- requirements
Module: adiv5_memap_seq

Interface
REQ-001 SHALL have parameter AP_SEL, default 8'h00: MEM-AP number, written to DP SELECT[31:24].
REQ-002 SHALL have parameter CSW_VAL, default 32'h23000002: value written to AP CSW (32-bit size, no auto-increment).
REQ-003 SHALL have port CLK, input, 1: the single clock; all logic on posedge.
REQ-004 SHALL have port RESET, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port REQ_VALID, input, 1: a client memory request is present.
REQ-006 SHALL have port REQ_READY, output, 1: the request is accepted on a cycle where REQ_VALID and REQ_READY are both high.
REQ-007 SHALL have port REQ_WRITE, input, 1: 1=write, 0=read.
REQ-008 SHALL have port REQ_ADDR, input, 32: byte address; bits [1:0] are ignored.
REQ-009 SHALL have port REQ_WDATA, input, 32: write data.
REQ-010 SHALL have port RSP_VALID, output, 1: a completion is present.
REQ-011 SHALL have port RSP_READY, input, 1: the client consumes the completion.
REQ-012 SHALL have port RSP_RDATA, output, 32: read data; 0 for writes and errors.
REQ-013 SHALL have port RSP_ERR, output, 1: 1 means the sequence was aborted on a non-OK ACK.
REQ-014 SHALL have port CMD_DATA, output, 40: the ADIv5 command {DATA[31:0], ADDR[5:0] (register>>2), APnDP, RnW}.
REQ-015 SHALL have port CMD_WREN, output, 1: command FIFO write strobe.
REQ-016 SHALL have port CMD_FULL, input, 1: command FIFO full.
REQ-017 SHALL have port RESP_DATA, input, 35: the ADIv5 response {DATA[31:0], STAT[2:0]}, valid the cycle after RESP_RDEN.
REQ-018 SHALL have port RESP_RDEN, output, 1: response FIFO read strobe.
REQ-019 SHALL have port RESP_EMPTY, input, 1: response FIFO empty.

Function
REQ-020 SHALL implement states IDLE, SEL, CSW, TAR, DRW, RDBUF, WAIT, DONE.
REQ-021 SHALL drive REQ_READY=1 only in IDLE; on acceptance it SHALL latch write, {addr[31:2],2'b00} and wdata.
REQ-022 SHALL go from IDLE to SEL if init_done=0, else to TAR if tar_valid=0 or tar_q!=addr[31:2], else to DRW.
REQ-023 SHALL make each issue state (SEL..RDBUF) pulse CMD_WREN for exactly one cycle on the first cycle CMD_FULL=0, then enter WAIT; it SHALL hold while CMD_FULL=1.
REQ-024 SHALL issue these commands: SEL = DP write ADDR=2, data {AP_SEL,24'h0}; CSW = AP write ADDR=0, data CSW_VAL; TAR = AP write ADDR=1, data address; DRW = AP ADDR=3, write data or read; RDBUF = DP read ADDR=3, data 0.
REQ-025 SHALL have at most one command outstanding: in WAIT, when RESP_EMPTY=0 it SHALL pulse RESP_RDEN once and evaluate STAT on the following cycle.
REQ-026 SHALL treat STAT==3'b100 as OK and advance: SEL→CSW; CSW→init_done=1, then TAR/DRW per REQ-022; TAR→tar_q=addr, tar_valid=1, DRW; DRW write→DONE; DRW read→RDBUF (DRW data discarded, posted read); RDBUF→capture DATA into RSP_RDATA, DONE.
REQ-027 SHALL, on any STAT≠3'b100, go to DONE with RSP_ERR=1 and RSP_RDATA=0, and clear init_done and tar_valid.
REQ-028 SHALL hold RSP_VALID=1 in DONE with stable RSP_RDATA/RSP_ERR until RSP_READY=1, then return to IDLE on the next cycle.
REQ-029 SHALL leave the TAR cache unchanged by DRW accesses (no auto-increment); a repeated address SHALL skip TAR.
REQ-030 SHALL keep DRW write data identical to the latched wdata even if REQ_WDATA changes after acceptance.

Reset
REQ-031 SHALL, while RESET=1, force the state to IDLE and drive REQ_READY=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, CMD_WREN=0, RESP_RDEN=0, CMD_DATA=0, with init_done=0 and tar_valid=0.
REQ-032 SHALL, on reset mid-sequence, drop any outstanding response handling; the FIFOs share the reset and are cleared externally.
REQ-033 SHALL raise REQ_READY on the first CLK edge after RESET deasserts.

Verification
REQ-034 SHALL cover first write to 0x20000004, data 0xDEADBEEF: commands in order SEL(0x00000000), CSW(0x23000002), TAR(0x20000004), DRW W(0xDEADBEEF); then RSP_VALID with RSP_ERR=0.
REQ-035 SHALL cover a read of 0x20000004 with responses DRW=0x11111111 and RDBUF=0xCAFEF00D: no TAR is issued, and RSP_RDATA=0xCAFEF00D.
REQ-036 SHALL cover a TAR ACK with STAT=3'b001: RSP_ERR=1 and RSP_RDATA=0; the next request reissues SEL, CSW and TAR.
REQ-037 SHALL cover CMD_FULL held high for 10 cycles at DRW: no CMD_WREN during that time and exactly one CMD_WREN after release.
REQ-038 SHALL cover RSP_READY held low for 5 cycles: RSP_VALID and the data stay stable, REQ_READY stays 0, and IDLE is reached one cycle after RSP_READY.
REQ-039 SHALL cover RESET asserted while in WAIT: outputs take REQ-031 values asynchronously, and the next request restarts from SEL.
